// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator: oversample, mid-bit and bit-rate pulses
// from a programmable integer+fractional clock divisor.
module baud_tick_gen #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OSR          = 16,
  parameter int DEFAULT_DIV  = 651,
  parameter int DEFAULT_FRAC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              resync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              div_load,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              bit_tick,
  output logic              baud,
  output logic              div_err
);

  localparam int PH_W = $clog2(OSR);
  localparam logic [DIV_W-1:0]  DIV_MIN  = DIV_W'(2);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEFAULT_DIV);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEFAULT_FRAC);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]   PH_MID   = PH_W'(OSR / 2 - 1);

  logic [DIV_W-1:0]  cur_int_q, cur_int_d;
  logic [FRAC_W-1:0] cur_frac_q, cur_frac_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pend_q, pend_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              baud_q, baud_d;
  logic              div_err_q, div_err_d;

  logic              ld_small;
  logic [DIV_W-1:0]  ld_int;
  logic [DIV_W:0]    period_len;
  logic              cnt_last;
  logic              tick;
  logic [FRAC_W:0]   acc_sum;

  assign ld_small   = div_int < DIV_MIN;
  assign ld_int     = ld_small ? DIV_MIN : div_int;
  assign period_len = {1'b0, cur_int_q} + {{DIV_W{1'b0}}, carry_q};
  assign cnt_last   = ({1'b0, cnt_q} + (DIV_W + 1)'(1)) == period_len;
  assign tick       = en && !resync && cnt_last;
  assign acc_sum    = {1'b0, acc_q} + {1'b0, cur_frac_q};

  always_comb begin
    cur_int_d  = cur_int_q;
    cur_frac_d = cur_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    phase_d    = phase_q;
    baud_d     = baud_q;
    div_err_d  = div_load && ld_small;

    if (resync) begin
      cnt_d   = '0;
      acc_d   = '0;
      carry_d = 1'b0;
      phase_d = '0;
      if (div_load) begin
        cur_int_d  = ld_int;
        cur_frac_d = div_frac;
        pend_d     = 1'b0;
      end
    end else if (!en) begin
      // Idle: a load takes effect at once and restarts the period, phase is kept.
      if (div_load) begin
        cur_int_d  = ld_int;
        cur_frac_d = div_frac;
        pend_d     = 1'b0;
        cnt_d      = '0;
        acc_d      = '0;
        carry_d    = 1'b0;
      end
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + PH_W'(1);
      baud_d  = ~baud_q;
      if (div_load) begin
        cur_int_d  = ld_int;
        cur_frac_d = div_frac;
        pend_d     = 1'b0;
        acc_d      = '0;
        carry_d    = 1'b0;
      end else if (pend_q) begin
        cur_int_d  = sh_int_q;
        cur_frac_d = sh_frac_q;
        pend_d     = 1'b0;
        acc_d      = '0;
        carry_d    = 1'b0;
      end else begin
        {carry_d, acc_d} = acc_sum;
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
      if (div_load) begin
        sh_int_d  = ld_int;
        sh_frac_d = div_frac;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_int_q  <= DEF_INT;
      cur_frac_q <= DEF_FRAC;
      sh_int_q   <= DEF_INT;
      sh_frac_q  <= DEF_FRAC;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      phase_q    <= '0;
      baud_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      cur_int_q  <= cur_int_d;
      cur_frac_q <= cur_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      phase_q    <= phase_d;
      baud_q     <= baud_d;
      div_err_q  <= div_err_d;
    end
  end

  // Registered outputs are masked so nothing leaks while reset is held.
  assign os_tick  = tick & ~reset;
  assign mid_tick = os_tick & (phase_q == PH_MID);
  assign bit_tick = os_tick & (phase_q == PH_LAST);
  assign baud     = baud_q & ~reset;
  assign div_err  = div_err_q & ~reset;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: per-cycle comparison against a closed-form tick
// schedule model, a vector table for start-up, and directed corner sequences.
module tb_baud_tick_gen;

  localparam int  OSR      = 16;
  localparam int  M        = 16;
  localparam int  DEF_DIV  = 651;
  localparam int  DEF_FRAC = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1, en = 1'b0, resync = 1'b0, div_load = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        os_tick, mid_tick, bit_tick, baud, div_err;

  always #5 clk = ~clk;

  baud_tick_gen dut (
    .clk(clk), .reset(reset), .en(en), .resync(resync),
    .div_int(div_int), .div_frac(div_frac), .div_load(div_load),
    .os_tick(os_tick), .mid_tick(mid_tick), .bit_tick(bit_tick),
    .baud(baud), .div_err(div_err)
  );

  int     tests = 0, fails = 0;
  longint cyc = 0;

  // Model: within a segment (since the last restart) with divisor I + F/M,
  // tick n (from 0) lands on enabled cycle (n+1)*I + floor(n*F/M).
  longint m_i = DEF_DIV, m_f = DEF_FRAC, m_shi = 0, m_shf = 0;
  longint m_e = 0, m_n = 0, m_ph0 = 0;
  bit     m_pend = 0, m_baud = 0, m_err = 0;
  bit     e_os, e_mid, e_bit;
  logic [4:0] obs;

  longint last_os = 0, prev_os = 0, last_bit = 0, prev_bit = 0;
  int     os_seen = 0, bit_seen = 0, err_cnt = 0, last_mid_os = 0;

  function automatic void check(string nm, longint got, longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void model_eval();
    longint ph;
    if (reset) begin
      e_os = 0; e_mid = 0; e_bit = 0;
    end else begin
      ph    = (m_ph0 + m_n) % OSR;
      e_os  = en && !resync && ((m_e + 1) == (m_n + 1) * m_i + (m_n * m_f) / M);
      e_mid = e_os && (ph == OSR / 2 - 1);
      e_bit = e_os && (ph == OSR - 1);
    end
  endfunction

  function automatic void model_update();
    longint ld, ph;
    if (reset) begin
      m_i = DEF_DIV; m_f = DEF_FRAC; m_pend = 0;
      m_e = 0; m_n = 0; m_ph0 = 0; m_baud = 0; m_err = 0;
      return;
    end
    ld    = (longint'(div_int) < 2) ? 2 : longint'(div_int);
    ph    = (m_ph0 + m_n) % OSR;
    m_err = div_load && (div_int < 2);
    if (resync) begin
      m_e = 0; m_n = 0; m_ph0 = 0;
      if (div_load) begin m_i = ld; m_f = div_frac; m_pend = 0; end
    end else if (!en) begin
      if (div_load) begin
        m_i = ld; m_f = div_frac; m_pend = 0;
        m_e = 0; m_n = 0; m_ph0 = ph;
      end
    end else if (e_os) begin
      m_baud = !m_baud;
      if (div_load || m_pend) begin
        m_i    = div_load ? ld : m_shi;
        m_f    = div_load ? longint'(div_frac) : m_shf;
        m_pend = 0;
        m_e = 0; m_n = 0; m_ph0 = (ph + 1) % OSR;
      end else begin
        m_e++; m_n++;
      end
    end else begin
      m_e++;
      if (div_load) begin m_shi = ld; m_shf = div_frac; m_pend = 1; end
    end
  endfunction

  task automatic cycle();
    @(negedge clk);
    model_eval();
    obs = {os_tick, mid_tick, bit_tick, baud, div_err};
    check("outputs{os,mid,bit,baud,err}", obs,
          {e_os, e_mid, e_bit, (reset ? 1'b0 : m_baud), (reset ? 1'b0 : m_err)});
    if (os_tick)  begin prev_os = last_os; last_os = cyc; os_seen++; end
    if (bit_tick) begin prev_bit = last_bit; last_bit = cyc; bit_seen++; end
    if (mid_tick) last_mid_os = os_seen;
    if (div_err)  err_cnt++;
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_os(input int budget, input string nm);
    int s = os_seen;
    int k = 0;
    while (os_seen == s && k < budget) begin cycle(); k++; end
    if (os_seen == s) begin
      tests++; fails++;
      $display("FAIL %s: no os_tick within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_bit(input int budget, input string nm);
    int s = bit_seen;
    int k = 0;
    while (bit_seen == s && k < budget) begin cycle(); k++; end
    if (bit_seen == s) begin
      tests++; fails++;
      $display("FAIL %s: no bit_tick within %0d cycles", nm, budget);
    end
  endtask

  typedef struct {
    bit         r, e, rs, ld;
    int         di, df;
    logic [4:0] exp;   // {os, mid, bit, baud, err}
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(bit r, bit e, bit rs, bit ld, int di, int df, logic [4:0] x);
    vec_t v;
    v.r = r; v.e = e; v.rs = rs; v.ld = ld; v.di = di; v.df = df; v.exp = x;
    return v;
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint t0, rs_t;
    int     s, base;

    // Start-up with divisor 4 + 8/16 loaded while idle: spacings 4,4,5.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 5'b00000);
    tbl[1]  = mk(0, 0, 0, 1, 4, 8, 5'b00000);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 5'b10000);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 5'b00010);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 5'b00010);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 5'b00010);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 5'b10010);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 5'b00000);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 5'b10000);

    #1;
    base = 0;
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].r; en = tbl[i].e; resync = tbl[i].rs; div_load = tbl[i].ld;
      div_int = 16'(tbl[i].di); div_frac = 4'(tbl[i].df);
      if (i == 2) base = os_seen;
      cycle();
      check($sformatf("table[%0d]", i), obs, tbl[i].exp);
    end
    div_load = 0;

    // Continue 4 + 8/16: mid on 8th tick, bit every 72 clocks.
    wait_bit(200, "frac_bit1");
    check("frac_mid_tick_index", last_mid_os - base, 8);
    wait_bit(200, "frac_bit2");
    check("frac_bit_spacing_a", last_bit - prev_bit, 72);
    wait_bit(200, "frac_bit3");
    check("frac_bit_spacing_b", last_bit - prev_bit, 72);

    // Defaults: first tick at cycle 651, 15x651 then 652, bit period 10417.
    reset = 1; en = 1;
    run(2);
    reset = 0;
    t0 = cyc;
    wait_os(700, "default_first");
    check("default_first_tick_cycle", last_os - t0 + 1, DEF_DIV);
    for (int i = 1; i <= 16; i++) begin
      wait_os(700, "default_spacing");
      check($sformatf("default_spacing[%0d]", i), last_os - prev_os,
            (i % 16 == 0) ? DEF_DIV + 1 : DEF_DIV);
    end
    wait_bit(11000, "default_bit");
    check("default_bit_spacing", last_bit - prev_bit, 10417);

    // Reset mid-period: restart timing from scratch.
    run(200);
    reset = 1;
    cycle();
    reset = 0;
    t0 = cyc;
    wait_os(700, "after_reset");
    check("after_reset_first_tick", last_os - t0 + 1, DEF_DIV);

    // Mid-period load: the running period finishes, then spacing 10.
    run(300);
    div_load = 1; div_int = 10; div_frac = 0;
    cycle();
    div_load = 0;
    wait_os(700, "midload_old");
    check("midload_old_period", last_os - prev_os, DEF_DIV);
    wait_os(20, "midload_new1");
    check("midload_spacing1", last_os - prev_os, 10);
    wait_os(20, "midload_new2");
    check("midload_spacing2", last_os - prev_os, 10);

    // Clamp: div_int=0 gives one div_err pulse, then spacing 2, bit every 32.
    s = err_cnt;
    div_load = 1; div_int = 0; div_frac = 0;
    cycle();
    div_load = 0;
    run(2);
    check("clamp_err_pulses", err_cnt - s, 1);
    wait_os(20, "clamp_apply");
    wait_os(5, "clamp_t1");
    check("clamp_spacing1", last_os - prev_os, 2);
    wait_os(5, "clamp_t2");
    check("clamp_spacing2", last_os - prev_os, 2);
    wait_bit(100, "clamp_bit1");
    wait_bit(100, "clamp_bit2");
    check("clamp_bit_spacing", last_bit - prev_bit, 32);

    // Resync at phase 9 mid-period.
    en = 0; div_load = 1; div_int = 10; div_frac = 0;
    cycle();
    div_load = 0; en = 1; resync = 1;
    cycle();
    resync = 0;
    for (int i = 0; i < 9; i++) wait_os(20, "resync_setup");
    run(3);
    s = os_seen;
    resync = 1;
    cycle();
    resync = 0;
    rs_t = cyc - 1;
    check("resync_no_tick", os_seen - s, 0);
    s = os_seen;
    wait_os(20, "resync_next");
    check("resync_next_tick_delay", last_os - rs_t, 10);
    wait_bit(200, "resync_bit");
    check("resync_ticks_to_bit", os_seen - s, 16);

    // Randomised traffic with small divisors against the model.
    en = 0; div_load = 1; div_int = 3; div_frac = 5;
    cycle();
    div_load = 0;
    for (int i = 0; i < 5000; i++) begin
      reset    = ($urandom_range(0, 499) == 0);
      en       = ($urandom_range(0, 7) != 0);
      resync   = ($urandom_range(0, 59) == 0);
      div_load = ($urandom_range(0, 39) == 0);
      div_int  = 16'($urandom_range(0, 12));
      div_frac = 4'($urandom_range(0, 15));
      cycle();
    end
    reset = 0; en = 0; resync = 0; div_load = 0;
    run(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
